// File: rtl/fb_write_arbiter.sv
// Round-robin, burst-limited framebuffer write arbiter for camera (req0) and overlay (req1) producers.
// Optional statistics counters are built when FB_ARB_STATS_EN is defined.
module fb_write_arbiter #(
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int ADDR_W    = 19,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_active,
    input  logic              req0_valid,
    input  logic [9:0]        req0_x,
    input  logic [9:0]        req0_y,
    input  logic [23:0]       req0_rgb,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [9:0]        req1_x,
    input  logic [9:0]        req1_y,
    input  logic [23:0]       req1_rgb,
    output logic              req1_ready,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [23:0]       fb_data,
`ifdef FB_ARB_STATS_EN
    input  logic              stats_clr,
    output logic [15:0]       stats_beats0,
    output logic [15:0]       stats_beats1,
    output logic [15:0]       stats_drops,
`endif
    output logic              drop
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GNT0 = 2'd1;
    localparam logic [1:0] S_GNT1 = 2'd2;

    localparam logic [31:0] H_LIM     = 32'(H_RES);
    localparam logic [31:0] V_LIM     = 32'(V_RES);
    localparam logic [7:0]  LAST_BEAT = 8'(MAX_BURST - 1);

    // Full-width y*H_RES + x; the default stride reduces to two shifts and an add.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
        if (H_RES == 640)
            return (ADDR_W'(y) << 9) + (ADDR_W'(y) << 7) + ADDR_W'(x);
        else
            return ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
    endfunction

    logic [1:0]        state_q, state_d;
    logic              rr_q, rr_d;
    logic [7:0]        burst_q, burst_d;
    logic              we_q, we_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [23:0]       data_q, data_d;

    logic              gnt0, gnt1;
    logic              beat0, beat1, beat;
    logic              last_beat;
    logic [9:0]        sel_x, sel_y;
    logic [23:0]       sel_rgb;
    logic              in_range;

    always_comb begin
        gnt0       = (state_q == S_GNT0);
        gnt1       = (state_q == S_GNT1);
        req0_ready = gnt0 & ~disp_active;
        req1_ready = gnt1 & ~disp_active;
        beat0      = req0_valid & req0_ready;
        beat1      = req1_valid & req1_ready;
        beat       = beat0 | beat1;
        last_beat  = beat && (burst_q == LAST_BEAT);
        sel_x      = gnt1 ? req1_x   : req0_x;
        sel_y      = gnt1 ? req1_y   : req0_y;
        sel_rgb    = gnt1 ? req1_rgb : req0_rgb;
        in_range   = (32'(sel_x) < H_LIM) && (32'(sel_y) < V_LIM);
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        burst_d = burst_q;
        case (state_q)
            S_IDLE: begin
                // Counter is held at zero here so every grant starts a fresh burst.
                burst_d = 8'd0;
                if (!disp_active) begin
                    if (req0_valid && (!req1_valid || !rr_q))
                        state_d = S_GNT0;
                    else if (req1_valid)
                        state_d = S_GNT1;
                end
            end
            S_GNT0: begin
                if (beat0)
                    burst_d = burst_q + 8'd1;
                if (last_beat || !req0_valid || disp_active) begin
                    state_d = S_IDLE;
                    rr_d    = 1'b1;
                end
            end
            S_GNT1: begin
                if (beat1)
                    burst_d = burst_q + 8'd1;
                if (last_beat || !req1_valid || disp_active) begin
                    state_d = S_IDLE;
                    rr_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Out-of-range beats are still consumed but turn into a drop pulse instead of a write.
    always_comb begin
        we_d   = beat & in_range;
        drop_d = beat & ~in_range;
        addr_d = addr_q;
        data_d = data_q;
        if (beat && in_range) begin
            addr_d = pix_addr(sel_x, sel_y);
            data_d = sel_rgb;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b0;
            burst_q <= 8'd0;
            we_q    <= 1'b0;
            drop_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= 24'd0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
            we_q    <= we_d;
            drop_q  <= drop_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign fb_we   = we_q;
    assign fb_addr = addr_q;
    assign fb_data = data_q;
    assign drop    = drop_q;

`ifdef FB_ARB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
        return (inc && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    logic [15:0] beats0_q, beats1_q, drops_q;

    // Clear has priority over a coincident increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beats0_q <= 16'd0;
            beats1_q <= 16'd0;
            drops_q  <= 16'd0;
        end else if (stats_clr) begin
            beats0_q <= 16'd0;
            beats1_q <= 16'd0;
            drops_q  <= 16'd0;
        end else begin
            beats0_q <= sat_inc(beats0_q, beat0 & in_range);
            beats1_q <= sat_inc(beats1_q, beat1 & in_range);
            drops_q  <= sat_inc(drops_q, drop_d);
        end
    end

    assign stats_beats0 = beats0_q;
    assign stats_beats1 = beats1_q;
    assign stats_drops  = drops_q;
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: reset, bursts, round-robin, preemption, range check, async reset.
module tb_fb_write_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        disp_active = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [9:0]  req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
    logic [23:0] req0_rgb = '0, req1_rgb = '0;
    logic        req0_ready, req1_ready;
    logic        fb_we, drop;
    logic [18:0] fb_addr;
    logic [23:0] fb_data;
`ifdef FB_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] stats_beats0, stats_beats1, stats_drops;
`endif

    fb_write_arbiter dut (
        .clk(clk), .reset(reset), .disp_active(disp_active),
        .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_rgb(req0_rgb),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_rgb(req1_rgb),
        .req1_ready(req1_ready),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
`ifdef FB_ARB_STATS_EN
        .stats_clr(stats_clr), .stats_beats0(stats_beats0), .stats_beats1(stats_beats1),
        .stats_drops(stats_drops),
`endif
        .drop(drop)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Producer streams and write/drop logs
    logic [9:0]  sx0[$], sy0[$], sx1[$], sy1[$];
    logic [23:0] sc0[$], sc1[$];
    int          idx0 = 0, idx1 = 0;
    logic        en0 = 1'b0, en1 = 1'b0;
    logic        rdy0_s, rdy1_s;
    logic [18:0] wa[$];
    logic [23:0] wd[$];
    int          wc[$], dc[$];
    int          both_err = 0, rdy_in_disp = 0;

    always @(negedge clk) begin
        if (fb_we) begin
            wa.push_back(fb_addr);
            wd.push_back(fb_data);
            wc.push_back(cyc);
        end
        if (drop) dc.push_back(cyc);
        if (fb_we && drop) both_err++;
        if (disp_active && (req0_ready || req1_ready)) rdy_in_disp++;
    end

    task automatic apply();
        req0_valid = en0 && (idx0 < sx0.size());
        req1_valid = en1 && (idx1 < sx1.size());
        if (req0_valid) begin req0_x = sx0[idx0]; req0_y = sy0[idx0]; req0_rgb = sc0[idx0]; end
        if (req1_valid) begin req1_x = sx1[idx1]; req1_y = sy1[idx1]; req1_rgb = sc1[idx1]; end
    endtask

    task automatic step();
        logic f0, f1;
        @(negedge clk);
        rdy0_s = req0_ready;
        rdy1_s = req1_ready;
        f0 = req0_valid & req0_ready;
        f1 = req1_valid & req1_ready;
        @(posedge clk); #1;
        if (f0) idx0++;
        if (f1) idx1++;
        apply();
    endtask

    task automatic clear_logs();
        wa.delete(); wd.delete(); wc.delete(); dc.delete();
        both_err = 0; rdy_in_disp = 0;
    endtask

    task automatic do_reset();
        en0 = 1'b0; en1 = 1'b0; disp_active = 1'b0;
        apply();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        idx0 = 0; idx1 = 0;
        sx0.delete(); sy0.delete(); sc0.delete();
        sx1.delete(); sy1.delete(); sc1.delete();
        clear_logs();
    endtask

    task automatic load0(input int n, input int y, input logic [7:0] tag, input logic [7:0] lo);
        for (int i = 0; i < n; i++) begin
            sx0.push_back(10'(i)); sy0.push_back(10'(y)); sc0.push_back({tag, 8'(i), lo});
        end
    endtask

    task automatic load1(input int n, input int y, input logic [7:0] tag, input logic [7:0] lo);
        for (int i = 0; i < n; i++) begin
            sx1.push_back(10'(i)); sy1.push_back(10'(y)); sc1.push_back({tag, 8'(i), lo});
        end
    endtask

    task automatic test_reset();
        #12;
        total++; if (fb_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", fb_we); end
        total++; if (fb_addr !== 19'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", fb_addr); end
        total++; if (fb_data !== 24'd0) begin bad++; $display("FAIL reset_data got=%h want=0", fb_data); end
        total++; if (drop !== 1'b0) begin bad++; $display("FAIL reset_drop got=%b want=0", drop); end
        total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", {req0_ready, req1_ready}); end
`ifdef FB_ARB_STATS_EN
        total++; if ({stats_beats0, stats_beats1, stats_drops} !== 48'd0) begin bad++; $display("FAIL reset_stats got=%h want=0", {stats_beats0, stats_beats1, stats_drops}); end
`endif
        do_reset();
    endtask

    task automatic test_single_burst();
        do_reset();
        load0(20, 1, 8'h00, 8'hA5);
        en0 = 1'b1;
        apply();
        step();
        total++; if (rdy0_s !== 1'b0) begin bad++; $display("FAIL sb_idle_ready got=%b want=0", rdy0_s); end
        step();
        total++; if (rdy0_s !== 1'b1) begin bad++; $display("FAIL sb_first_ready got=%b want=1", rdy0_s); end
        for (int k = 0; k < 80 && wa.size() < 20; k++) step();
        step();
        total++; if (wa.size() != 20) begin bad++; $display("FAIL sb_count got=%0d want=20", wa.size()); end
        for (int i = 0; i < 20; i++) begin
            if (i < wa.size()) begin
                total++;
                if (wa[i] !== 19'(640 + i) || wd[i] !== {8'h00, 8'(i), 8'hA5}) begin
                    bad++; $display("FAIL sb_beat%0d got=%0d/%h want=%0d/%h", i, wa[i], wd[i], 640 + i, {8'h00, 8'(i), 8'hA5});
                end
            end
        end
        if (wa.size() == 20) begin
            total++; if (wc[15] - wc[0] != 15) begin bad++; $display("FAIL sb_burst_span got=%0d want=15", wc[15] - wc[0]); end
            total++; if (wc[16] - wc[15] != 2) begin bad++; $display("FAIL sb_idle_gap got=%0d want=2", wc[16] - wc[15]); end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        load0(40, 2, 8'h00, 8'h5A);
        load1(40, 3, 8'h01, 8'hC3);
        en0 = 1'b1; en1 = 1'b1;
        apply();
        for (int k = 0; k < 150 && wa.size() < 48; k++) step();
        total++; if (wa.size() < 48) begin bad++; $display("FAIL rr_count got=%0d want>=48", wa.size()); end
        for (int j = 0; j < 48; j++) begin
            int          x;
            int          ea;
            logic [23:0] ed;
            if (j < 16)      begin x = j;      ea = 1280 + x; ed = {8'h00, 8'(x), 8'h5A}; end
            else if (j < 32) begin x = j - 16; ea = 1920 + x; ed = {8'h01, 8'(x), 8'hC3}; end
            else             begin x = j - 16; ea = 1280 + x; ed = {8'h00, 8'(x), 8'h5A}; end
            if (j < wa.size()) begin
                total++;
                if (wa[j] !== 19'(ea) || wd[j] !== ed) begin
                    bad++; $display("FAIL rr_beat%0d got=%0d/%h want=%0d/%h", j, wa[j], wd[j], ea, ed);
                end
            end
        end
        if (wa.size() >= 48) begin
            total++; if (wc[16] - wc[15] != 2) begin bad++; $display("FAIL rr_gap01 got=%0d want=2", wc[16] - wc[15]); end
            total++; if (wc[32] - wc[31] != 2) begin bad++; $display("FAIL rr_gap10 got=%0d want=2", wc[32] - wc[31]); end
        end
    endtask

    task automatic test_preempt();
        do_reset();
        load1(20, 5, 8'h01, 8'h33);
        en1 = 1'b1;
        apply();
        for (int k = 0; k < 40 && idx1 < 5; k++) step();
        disp_active = 1'b1;
        step();
        total++; if (rdy1_s !== 1'b0) begin bad++; $display("FAIL pre_ready_drop got=%b want=0", rdy1_s); end
        for (int k = 0; k < 6; k++) step();
        total++; if (wa.size() != 5) begin bad++; $display("FAIL pre_writes got=%0d want=5", wa.size()); end
        total++; if (idx1 != 5 || rdy_in_disp != 0) begin bad++; $display("FAIL pre_no_grant got=idx%0d/rdy%0d want=idx5/rdy0", idx1, rdy_in_disp); end
        disp_active = 1'b0;
        for (int k = 0; k < 60 && wa.size() < 20; k++) step();
        total++; if (wa.size() != 20) begin bad++; $display("FAIL pre_resume_count got=%0d want=20", wa.size()); end
        for (int i = 0; i < 20; i++) begin
            if (i < wa.size()) begin
                total++;
                if (wa[i] !== 19'(3200 + i)) begin bad++; $display("FAIL pre_addr%0d got=%0d want=%0d", i, wa[i], 3200 + i); end
            end
        end
        if (wa.size() == 20) begin
            total++; if (wc[19] - wc[5] != 14) begin bad++; $display("FAIL pre_new_burst got=%0d want=14", wc[19] - wc[5]); end
            total++; if (wc[5] - wc[4] < 8) begin bad++; $display("FAIL pre_pause got=%0d want>=8", wc[5] - wc[4]); end
        end
    endtask

    task automatic test_range();
        do_reset();
        sx0.push_back(10'd639); sy0.push_back(10'd479); sc0.push_back(24'h123456);
        sx0.push_back(10'd640); sy0.push_back(10'd0);   sc0.push_back(24'hABCDEF);
        sx0.push_back(10'd0);   sy0.push_back(10'd480); sc0.push_back(24'h0F0F0F);
        en0 = 1'b1;
        apply();
        for (int k = 0; k < 20 && idx0 < 3; k++) step();
        for (int k = 0; k < 3; k++) step();
        total++; if (wa.size() != 1) begin bad++; $display("FAIL rng_writes got=%0d want=1", wa.size()); end
        if (wa.size() >= 1) begin
            total++; if (wa[0] !== 19'd307199 || wd[0] !== 24'h123456) begin bad++; $display("FAIL rng_write got=%0d/%h want=307199/123456", wa[0], wd[0]); end
        end
        total++; if (dc.size() != 2) begin bad++; $display("FAIL rng_drops got=%0d want=2", dc.size()); end
        if (wa.size() >= 1 && dc.size() == 2) begin
            total++; if (dc[0] != wc[0] + 1 || dc[1] != wc[0] + 2) begin bad++; $display("FAIL rng_drop_timing got=%0d,%0d want=%0d,%0d", dc[0], dc[1], wc[0] + 1, wc[0] + 2); end
        end
        total++; if (both_err != 0) begin bad++; $display("FAIL rng_we_with_drop got=%0d want=0", both_err); end
        total++; if (fb_addr !== 19'd307199 || fb_data !== 24'h123456) begin bad++; $display("FAIL rng_hold got=%0d/%h want=307199/123456", fb_addr, fb_data); end
`ifdef FB_ARB_STATS_EN
        total++; if (stats_beats0 !== 16'd1 || stats_beats1 !== 16'd0 || stats_drops !== 16'd2) begin
            bad++; $display("FAIL rng_stats got=%0d/%0d/%0d want=1/0/2", stats_beats0, stats_beats1, stats_drops);
        end
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        total++; if ({stats_beats0, stats_beats1, stats_drops} !== 48'd0) begin bad++; $display("FAIL stats_clr got=%h want=0", {stats_beats0, stats_beats1, stats_drops}); end
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        load1(10, 7, 8'h01, 8'h77);
        en1 = 1'b1;
        apply();
        for (int k = 0; k < 20 && idx1 < 3; k++) step();
        total++; if (fb_we !== 1'b1 || req1_ready !== 1'b1) begin bad++; $display("FAIL ar_pre got=%b%b want=11", fb_we, req1_ready); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (fb_we !== 1'b0 || drop !== 1'b0) begin bad++; $display("FAIL ar_we_drop got=%b%b want=00", fb_we, drop); end
        total++; if (fb_addr !== 19'd0 || fb_data !== 24'd0) begin bad++; $display("FAIL ar_addr_data got=%0d/%h want=0/0", fb_addr, fb_data); end
        total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL ar_ready got=%b want=00", {req0_ready, req1_ready}); end
        @(posedge clk); #1;
        reset = 1'b0;
        idx0 = 0; idx1 = 0;
        sx1.delete(); sy1.delete(); sc1.delete();
        load0(4, 8, 8'h00, 8'h11);
        load1(4, 9, 8'h01, 8'h22);
        clear_logs();
        en0 = 1'b1; en1 = 1'b1;
        apply();
        step();
        total++; if (wa.size() != 0) begin bad++; $display("FAIL ar_no_write got=%0d want=0", wa.size()); end
        for (int k = 0; k < 20 && wa.size() < 1; k++) step();
        total++; if (wa.size() < 1) begin bad++; $display("FAIL ar_first_write got=none want=req0"); end
        else if (wa[0] !== 19'd5120 || wd[0] !== 24'h000011) begin
            bad++; $display("FAIL ar_first_write got=%0d/%h want=5120/000011", wa[0], wd[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_preempt();
        test_range();
        test_async_reset();
        en0 = 1'b0; en1 = 1'b0;
        apply();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Arbitrates single-port framebuffer write access between two pixel producers, the camera capture path (requester 0) and the digit/overlay renderer (requester 1). It sits between those producers and the framebuffer that feeds the Graphics_Controller scan-out. It yields the port entirely whenever the display is in its active read window. Grants are bursty and round-robin, with coordinate-to-address conversion and an out-of-range drop.

## Interface
- H_RES, 640, visible pixels per line; also the address stride.
- V_RES, 480, visible lines.
- ADDR_W, 19, framebuffer address width.
- MAX_BURST, 16, maximum beats per grant; legal range is 1..255.
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- disp_active  in  1  high while scan-out owns the framebuffer port.
- req0_valid, req1_valid  in  1  requester has a pixel.
- req0_x, req1_x  in  10  pixel column.
- req0_y, req1_y  in  10  pixel row.
- req0_rgb, req1_rgb  in  24  pixel colour, R[23:16] G[15:8] B[7:0].
- req0_ready, req1_ready  out  1  beat accepted when valid & ready.
- fb_we  out  1  framebuffer write strobe.
- fb_addr  out  ADDR_W  write address.
- fb_data  out  24  write data.
- drop  out  1  one-cycle pulse: an accepted beat was out of range.

## Operation
- States: IDLE, GNT0, GNT1. A round-robin pointer `rr` is 1 bit; reset sets it to 0.
- **IDLE:**
  - ready outputs are 0.
  - If disp_active=0 and exactly one valid is high, go to that requester's GNT state.
  - If both are high, go to GNT[rr].
  - If disp_active=1 or no valid is high, stay in IDLE.
- **GNTn:**
  - reqn_ready = ~disp_active (combinational). The other requester's ready is 0.
  - A beat transfers when reqn_valid & reqn_ready. Each beat increments an 8-bit burst counter, which clears on GNT entry.
- **Leaving GNTn:** the next state is IDLE when any of these holds:
  - the MAX_BURST-th beat transfers this cycle;
  - reqn_valid=0;
  - disp_active=1.
- On every exit from GNTn, rr becomes ~n.
- **Address:** fb_addr = y*H_RES + x, computed at full ADDR_W width. For the default H_RES it is (y<<9)+(y<<7)+x. No truncation is allowed for in-range coordinates.
- **Range check:** x >= H_RES or y >= V_RES marks the beat out of range. The beat is still accepted (ready honoured). fb_we stays 0 for it and drop pulses instead.
- fb_addr and fb_data update only on in-range beats and hold their value otherwise.

## Timing
- Arbitration costs one IDLE cycle: valid rising in IDLE at cycle T puts the grant at T+1, so the first ready is at T+1.
- Write latency is one cycle: a beat transferred at edge T gives fb_we/fb_addr/fb_data at T+1. drop uses the same latency.
- Maximum throughput is MAX_BURST beats per MAX_BURST+1 cycles per requester.
- disp_active rising during GNT:
  - ready drops the same cycle and no beat transfers.
  - The state goes to IDLE next.
  - A write already registered from the previous cycle still issues.
  - Producers must tolerate one trailing fb_we after disp_active rises.
- Reset values are all 0: fb_we, fb_addr, fb_data, drop, both readys, rr, burst counter. The state is IDLE.
- Reset asserted mid-burst aborts the burst. Any pending registered write is discarded, and no fb_we occurs on the cycle after reset deasserts.

## Configuration
- `FB_ARB_STATS_EN`
  - **Defined:** adds input stats_clr (1) and three outputs, each 16 bits and saturating at 16'hFFFF:
    - stats_beats0: counts in-range writes from requester 0.
    - stats_beats1: counts in-range writes from requester 1.
    - stats_drops: counts drop pulses.
  - Each counter increments on the same edge its fb_we or drop is registered.
  - All three counters are cleared by reset or stats_clr. If stats_clr and an increment coincide, the clear wins.
  - **Not defined:** these ports and counters do not exist, and the rest of the behaviour is identical.

## Test plan
- **Single burst:** reset, disp_active=0, req0 holds valid for 20 beats at y=1, x=0..19 → beats 0..15 are written with fb_addr 640..655. One IDLE gap follows, then a second grant writes 656..659.
- **Round-robin:** both valid continuously from reset → grants run GNT0 (16 beats), GNT1 (16), GNT0, with exactly one idle cycle between bursts.
- **Display preemption:** req1 is streaming, disp_active rises after beat 5 → req1_ready=0 the same cycle and exactly 5 fb_we pulses occur (the last one a cycle after the rise). There are no grants while disp_active=1, and req1 resumes as a new burst after it falls.
- **Range check:** req0 beats (639,479), (640,0), (0,480) → one write at fb_addr 307199, then two drop pulses with no fb_we. With `FB_ARB_STATS_EN`, stats_beats0=1 and stats_drops=2.
- **Async reset mid-burst:** assert reset between edges during GNT1 beat 3 → all outputs read 0 before the next edge, no write appears afterward, and the first grant after reset goes to req0 when both are valid.
